// File: rtl/alu_sequencer_if.sv
// Decoder-side handshake for alu_sequencer: decoded instruction fields in, busy/done/illegal back.
interface alu_sequencer_if #(
  parameter int unsigned RF_AW = 3,
  parameter int unsigned DW    = 8
);
  logic             start;
  logic [3:0]       op;
  logic [RF_AW-1:0] rd_sel;
  logic [RF_AW-1:0] rs_sel;
  logic [DW-1:0]    imm;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, op, rd_sel, rs_sel, imm,
    input  busy, done, illegal
  );

  modport slave (
    input  start, op, rd_sel, rs_sel, imm,
    output busy, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing one ALU instruction: RF read(s), ALU drive, flag latch, write-back.
// Build macro ALU_MUL_EN makes op 12 (MUL) legal as an 8-cycle shift-add multiply; otherwise op 12 is illegal.
module alu_sequencer #(
  parameter int unsigned RF_AW = 3,
  parameter int unsigned DW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  alu_sequencer_if.slave   dec,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [DW-1:0]    rf_rdata,
  output logic [DW-1:0]    alu_x,
  output logic [DW-1:0]    alu_y,
  output logic [3:0]       alu_op,
  input  logic [2*DW-1:0]  alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [DW-1:0]    acc_hi,
  output logic [3:0]       flags_q
);
  localparam int unsigned PW = 2 * DW;
  localparam logic [3:0] OP_CM       = 4'd4;
  localparam logic [3:0] OP_CMI      = 4'd5;
  localparam logic [3:0] OP_BASE_MAX = 4'd11;
  localparam logic [3:0] OP_MUL      = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WB,
`ifdef ALU_MUL_EN
    S_MUL,
`endif
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RF_AW-1:0] rs_q, rs_d;
  logic [DW-1:0]    imm_q, imm_d;
  logic [DW-1:0]    x_q, x_d;
  logic [RF_AW-1:0] rf_raddr_q, rf_raddr_d;
  logic [DW-1:0]    alu_x_q, alu_x_d;
  logic [DW-1:0]    alu_y_q, alu_y_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
  logic [DW-1:0]    acc_hi_q, acc_hi_d;
  logic [3:0]       flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic op_legal;
  logic is_unary;
  logic reg_bin;
  logic unused_flags;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = $clog2(DW);
  logic [DW-1:0] y_q, y_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mul_y;
  logic [PW-1:0] mul_addend;

  // First MUL cycle sees y straight off the RF read port; later cycles use the held copy.
  assign mul_y      = (cnt_q == '0) ? rf_rdata : y_q;
  assign mul_addend = mul_y[cnt_q] ? (PW'(x_q) << cnt_q) : '0;
  assign op_legal   = (dec.op <= OP_MUL);
`else
  assign op_legal   = (dec.op <= OP_BASE_MAX);
`endif

  assign is_unary     = (op_q == OP_CM) || (op_q == OP_CMI);
  assign reg_bin      = !op_q[0] && !is_unary;
  // ALU zero and reserved flag bits are never used; zero is derived here.
  assign unused_flags = ^{alu_flags[3], alu_flags[1]};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    x_d        = x_q;
    rf_raddr_d = rf_raddr_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_op_d   = alu_op_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    acc_hi_d   = acc_hi_q;
    flags_d    = flags_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
`ifdef ALU_MUL_EN
    y_d        = y_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (dec.start) begin
          op_d       = dec.op;
          rs_d       = dec.rs_sel;
          imm_d      = dec.imm;
          rf_waddr_d = dec.rd_sel;
          busy_d     = 1'b1;
          if (op_legal) begin
            rf_raddr_d = dec.rd_sel;
            state_d    = S_RD_X;
          end else begin
            state_d    = S_ERR;
          end
        end
      end
      S_RD_X: begin
        if (reg_bin) begin
          rf_raddr_d = rs_q;
          state_d    = S_RD_Y;
        end else begin
          state_d    = S_EXEC;
        end
      end
      S_RD_Y: begin
        x_d     = rf_rdata;
        state_d = S_EXEC;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          prod_d  = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
`endif
      end
      S_EXEC: begin
        alu_op_d = op_q;
        if (reg_bin) begin
          alu_x_d = x_q;
          alu_y_d = rf_rdata;
        end else begin
          alu_x_d = rf_rdata;
          alu_y_d = is_unary ? '0 : imm_q;
        end
        state_d = S_WB;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (cnt_q == '0) begin
          y_d = rf_rdata;
        end
        prod_d = prod_q + mul_addend;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_WB;
        end
      end
`endif
      S_WB: begin
        rf_we_d    = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        rf_wdata_d = alu_out[DW-1:0];
        acc_hi_d   = alu_out[PW-1:DW];
        flags_d    = {1'b0, alu_flags[2], ~|alu_out[DW-1:0], alu_flags[0]};
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          rf_wdata_d = prod_q[DW-1:0];
          acc_hi_d   = prod_q[PW-1:DW];
          flags_d    = {1'b0, prod_q[PW-1], ~|prod_q, |prod_q[PW-1:DW]};
        end
`endif
        state_d    = S_IDLE;
      end
      S_ERR: begin
        done_d    = 1'b1;
        illegal_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rs_q       <= '0;
      imm_q      <= '0;
      x_q        <= '0;
      rf_raddr_q <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_op_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      acc_hi_q   <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_MUL_EN
      y_q        <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
      x_q        <= x_d;
      rf_raddr_q <= rf_raddr_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_op_q   <= alu_op_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      acc_hi_q   <= acc_hi_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
`ifdef ALU_MUL_EN
      y_q        <= y_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rf_raddr    = rf_raddr_q;
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign alu_op      = alu_op_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign acc_hi      = acc_hi_q;
  assign dec.busy    = busy_q;
  assign dec.done    = done_q;
  assign dec.illegal = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: RF and ALU models around the DUT, directed plus random ops.
module tb_alu_sequencer;
  localparam int unsigned RF_AW = 3;
  localparam int unsigned DW    = 8;
  localparam int TIMEOUT = 40;

  logic             clock;
  logic             reset;
  logic [RF_AW-1:0] rf_raddr;
  logic [DW-1:0]    rf_rdata;
  logic [DW-1:0]    alu_x;
  logic [DW-1:0]    alu_y;
  logic [3:0]       alu_op;
  logic [2*DW-1:0]  alu_out;
  logic [3:0]       alu_flags;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic [DW-1:0]    acc_hi;
  logic [3:0]       flags_q;

  alu_sequencer_if #(.RF_AW(RF_AW), .DW(DW)) dec ();

  alu_sequencer #(.RF_AW(RF_AW), .DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .dec       (dec),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .acc_hi    (acc_hi),
    .flags_q   (flags_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_mem [8];
  logic [3:0]    exp_flags;
  logic [DW-1:0] exp_hi;

  // Register file: synchronous read, data valid the cycle after the address.
  always @(posedge clock) begin
    rf_rdata <= mem[rf_raddr];
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  // ALU: zero flag and reserved bit deliberately driven high so the DUT must derive its own.
  always_comb begin
    alu_out   = '0;
    alu_flags = 4'b1010;
    case (alu_op)
      4'd0, 4'd1: begin alu_out = {8'h00, alu_x} + {8'h00, alu_y}; alu_flags[0] = alu_out[8]; end
      4'd2, 4'd3: begin alu_out = {8'h00, alu_x} - {8'h00, alu_y}; alu_flags[0] = (alu_x < alu_y); end
      4'd4, 4'd5: alu_out = {8'h00, ~alu_x};
      4'd6, 4'd7: alu_out = {8'h00, alu_x & alu_y};
      4'd8, 4'd9: alu_out = {8'h00, alu_x | alu_y};
      4'd10, 4'd11: alu_out = {8'h00, alu_x ^ alu_y};
      default: alu_out = 16'hDEAD;
    endcase
    alu_flags[2] = alu_out[7];
  end

  function automatic bit ref_legal(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return op <= 4'd12;
`else
    return op <= 4'd11;
`endif
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    if (!ref_legal(op)) return 1;
    if (op == 4'd12) return 11;
    if (op[0] || op == 4'd4) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] ref_y(input logic [3:0] op, input logic [7:0] rs_val, input logic [7:0] imm);
    if (op == 4'd4 || op == 4'd5) return 8'h00;
    return op[0] ? imm : rs_val;
  endfunction

  // Returns {flags[3:0], hi[7:0], lo[7:0]} from plain integer arithmetic.
  function automatic logic [19:0] ref_calc(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int r;
    logic c;
    logic [15:0] full;
    logic [3:0] f;
    c = 1'b0;
    case (op)
      4'd0, 4'd1: begin r = int'(x) + int'(y); c = (r > 255); end
      4'd2, 4'd3: begin r = int'(x) - int'(y); c = (x < y); end
      4'd4, 4'd5: r = 255 - int'(x);
      4'd6, 4'd7: r = int'(x & y);
      4'd8, 4'd9: r = int'(x | y);
      4'd10, 4'd11: r = int'(x ^ y);
      default: r = int'(x) * int'(y);
    endcase
    full = 16'(r);
    if (op == 4'd12) f = {1'b0, full[15], (full == 16'h0000), (full[15:8] != 8'h00)};
    else f = {1'b0, full[7], (full[7:0] == 8'h00), c};
    return {f, full};
  endfunction

  task automatic preload(input logic [2:0] r, input logic [7:0] v);
    mem[r] = v;
    exp_mem[r] = v;
  endtask

  task automatic model_commit(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] imm);
    logic [19:0] res;
    if (ref_legal(op)) begin
      res = ref_calc(op, exp_mem[rd], ref_y(op, exp_mem[rs], imm));
      exp_mem[rd] = res[7:0];
      exp_hi = res[15:8];
      exp_flags = res[19:16];
    end
  endtask

  // Issues one instruction and returns at the done cycle (or after the cycle budget).
  task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [7:0] imm, input bit poke,
                        output int lat, output int busy_cyc, output int we_cnt,
                        output bit rs_seen, output bit to);
    dec.op = op; dec.rd_sel = rd; dec.rs_sel = rs; dec.imm = imm; dec.start = 1'b1;
    @(posedge clock); #1;
    dec.start = 1'b0;
    lat = 0; busy_cyc = 0; we_cnt = 0; rs_seen = 1'b0; to = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (dec.busy) busy_cyc++;
      if (rf_we) we_cnt++;
      if (rf_raddr == rs) rs_seen = 1'b1;
      if (dec.done) begin lat = k; to = 1'b0; break; end
      if (poke && k < 2) begin
        dec.start = 1'b1;
        dec.op = 4'($urandom_range(0, 15));
        dec.rd_sel = 3'($urandom_range(0, 7));
        dec.rs_sel = 3'($urandom_range(0, 7));
        dec.imm = 8'($urandom_range(0, 255));
      end else begin
        dec.start = 1'b0;
      end
      @(posedge clock); #1;
    end
    dec.start = 1'b0;
  endtask

  function automatic logic [49:0] all_outputs();
    return {rf_raddr, alu_x, alu_y, alu_op, rf_we, rf_waddr, rf_wdata, acc_hi, flags_q,
            dec.busy, dec.done, dec.illegal};
  endfunction

  task automatic test_reset();
    logic [49:0] obs;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    obs = all_outputs();
    n_vec++; if (obs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    reset = 1'b1;
    exp_flags = '0; exp_hi = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_sum();
    int lat, bc, wc, extra; bit rss, to;
    preload(3'd1, 8'h7F); preload(3'd2, 8'h01);
    run_op(4'd0, 3'd1, 3'd2, 8'h00, 1'b1, lat, bc, wc, rss, to);
    n_vec++; if (to || lat != 4) begin n_err++; $display("FAIL sum_latency: got %0d (timeout %0d) want 4", lat, to); end
    n_vec++; if (bc != 4) begin n_err++; $display("FAIL sum_busy_cycles: got %0d want 4", bc); end
    n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 8'h80) begin
      n_err++; $display("FAIL sum_write: we=%b addr=%0d data=%h want 1/1/80", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (flags_q !== 4'b0100 || acc_hi !== 8'h00) begin
      n_err++; $display("FAIL sum_flags: flags=%b hi=%h want 0100/00", flags_q, acc_hi); end
    model_commit(4'd0, 3'd1, 3'd2, 8'h00);
    extra = 0;
    repeat (3) begin @(posedge clock); #1; if (dec.done || dec.busy || rf_we) extra++; end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL sum_quiet_after: %0d active cycles want 0", extra); end
    n_vec++; if (mem[1] !== 8'h80) begin n_err++; $display("FAIL sum_rf_r1: got %h want 80", mem[1]); end
  endtask

  task automatic test_cm();
    int lat, bc, wc; bit rss, to;
    preload(3'd0, 8'hAA); preload(3'd3, 8'h5A);
    run_op(4'd4, 3'd0, 3'd3, 8'hC3, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (to || lat != 3) begin n_err++; $display("FAIL cm_latency: got %0d want 3", lat); end
    n_vec++; if (rss) begin n_err++; $display("FAIL cm_rs_read: rf_raddr reached rs_sel=3, want never"); end
    n_vec++; if (rf_wdata !== 8'h55 || flags_q !== 4'b0000) begin
      n_err++; $display("FAIL cm_result: data=%h flags=%b want 55/0000", rf_wdata, flags_q); end
    n_vec++; if (alu_y !== 8'h00 || alu_op !== 4'd4) begin
      n_err++; $display("FAIL cm_alu_drive: y=%h op=%0d want 00/4", alu_y, alu_op); end
    model_commit(4'd4, 3'd0, 3'd3, 8'hC3);
    @(posedge clock); #1;
  endtask

  task automatic test_sbi();
    int lat, bc, wc; bit rss, to;
    preload(3'd3, 8'h05);
    run_op(4'd3, 3'd3, 3'd0, 8'h05, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (to || lat != 3) begin n_err++; $display("FAIL sbi_eq_latency: got %0d want 3", lat); end
    n_vec++; if (rf_wdata !== 8'h00 || flags_q !== 4'b0010) begin
      n_err++; $display("FAIL sbi_eq_result: data=%h flags=%b want 00/0010", rf_wdata, flags_q); end
    model_commit(4'd3, 3'd3, 3'd0, 8'h05);
    @(posedge clock); #1;
    preload(3'd3, 8'h05);
    run_op(4'd3, 3'd3, 3'd0, 8'h06, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (rf_wdata !== 8'hFF || flags_q !== 4'b0101 || acc_hi !== 8'hFF) begin
      n_err++; $display("FAIL sbi_borrow: data=%h flags=%b hi=%h want FF/0101/FF", rf_wdata, flags_q, acc_hi); end
    model_commit(4'd3, 3'd3, 3'd0, 8'h06);
    @(posedge clock); #1;
  endtask

  task automatic test_illegal();
    int lat, bc, wc, extra; bit rss, to;
    for (int op = 13; op <= 15; op++) begin
      run_op(4'(op), 3'(op - 12), 3'd2, 8'h11, (op == 14), lat, bc, wc, rss, to);
      n_vec++; if (to || lat != 1 || dec.illegal !== 1'b1) begin
        n_err++; $display("FAIL illegal_%0d_pulse: lat=%0d illegal=%b want 1/1", op, lat, dec.illegal); end
      n_vec++; if (wc != 0 || flags_q !== exp_flags || acc_hi !== exp_hi) begin
        n_err++; $display("FAIL illegal_%0d_side: we=%0d flags=%b hi=%h want 0/%b/%h", op, wc, flags_q, acc_hi, exp_flags, exp_hi); end
      extra = 0;
      repeat (2) begin @(posedge clock); #1; if (rf_we || dec.illegal || dec.busy) extra++; end
      n_vec++; if (extra != 0) begin n_err++; $display("FAIL illegal_%0d_after: %0d active cycles want 0", op, extra); end
    end
  endtask

  task automatic test_reset_midop();
    int lat, bc, wc, bad; bit rss, to; logic [49:0] obs;
    preload(3'd1, 8'h11); preload(3'd2, 8'h22);
    dec.op = 4'd0; dec.rd_sel = 3'd1; dec.rs_sel = 3'd2; dec.imm = 8'h00; dec.start = 1'b1;
    @(posedge clock); #1; dec.start = 1'b0;
    @(posedge clock); #1;
    n_vec++; if (rf_raddr !== 3'd2) begin n_err++; $display("FAIL midop_rd_y_addr: got %0d want 2", rf_raddr); end
    reset = 1'b0; bad = 0;
    repeat (2) begin @(posedge clock); #1; if (rf_we) bad++; end
    obs = all_outputs();
    n_vec++; if (obs !== '0) begin n_err++; $display("FAIL midop_reset_outputs: got %h want 0", obs); end
    reset = 1'b1;
    exp_flags = '0; exp_hi = '0;
    repeat (3) begin @(posedge clock); #1; if (rf_we || dec.busy || dec.done) bad++; end
    n_vec++; if (bad != 0 || mem[1] !== 8'h11) begin
      n_err++; $display("FAIL midop_abort: %0d active cycles, R1=%h want 0/11", bad, mem[1]); end
    run_op(4'd0, 3'd1, 3'd2, 8'h00, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (to || lat != 4 || rf_wdata !== 8'h33) begin
      n_err++; $display("FAIL midop_rerun: lat=%0d data=%h want 4/33", lat, rf_wdata); end
    model_commit(4'd0, 3'd1, 3'd2, 8'h00);
    @(posedge clock); #1;
  endtask

  task automatic test_mul();
    int lat, bc, wc; bit rss, to;
    preload(3'd4, 8'hFF); preload(3'd5, 8'hFF);
    run_op(4'd12, 3'd4, 3'd5, 8'h00, 1'b0, lat, bc, wc, rss, to);
`ifdef ALU_MUL_EN
    n_vec++; if (to || lat != 11 || dec.illegal !== 1'b0) begin
      n_err++; $display("FAIL mul_latency: lat=%0d illegal=%b want 11/0", lat, dec.illegal); end
    n_vec++; if (rf_wdata !== 8'h01 || acc_hi !== 8'hFE || flags_q !== 4'b0101) begin
      n_err++; $display("FAIL mul_result: data=%h hi=%h flags=%b want 01/FE/0101", rf_wdata, acc_hi, flags_q); end
`else
    n_vec++; if (to || lat != 1 || dec.illegal !== 1'b1 || wc != 0) begin
      n_err++; $display("FAIL mul_disabled: lat=%0d illegal=%b we=%0d want 1/1/0", lat, dec.illegal, wc); end
`endif
    model_commit(4'd12, 3'd4, 3'd5, 8'h00);
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc, wc; bit rss, to;
    preload(3'd6, 8'h10); preload(3'd7, 8'h22);
    run_op(4'd10, 3'd6, 3'd7, 8'h00, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (to || rf_wdata !== 8'h32) begin n_err++; $display("FAIL b2b_first: data=%h want 32", rf_wdata); end
    model_commit(4'd10, 3'd6, 3'd7, 8'h00);
    run_op(4'd1, 3'd6, 3'd0, 8'h0E, 1'b0, lat, bc, wc, rss, to);
    n_vec++; if (to || lat != 3 || rf_wdata !== 8'h40 || flags_q !== 4'b0000) begin
      n_err++; $display("FAIL b2b_second: lat=%0d data=%h flags=%b want 3/40/0000", lat, rf_wdata, flags_q); end
    model_commit(4'd1, 3'd6, 3'd0, 8'h0E);
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int lat, bc, wc; bit rss, to;
    logic [3:0] op; logic [2:0] rd, rs; logic [7:0] imm; logic [19:0] res; bit legal;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      rd = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      imm = 8'($urandom_range(0, 255));
      legal = ref_legal(op);
      res = ref_calc(op, exp_mem[rd], ref_y(op, exp_mem[rs], imm));
      run_op(op, rd, rs, imm, 1'($urandom_range(0, 1)), lat, bc, wc, rss, to);
      n_vec++; if (to || lat != ref_lat(op) || dec.illegal !== !legal) begin
        n_err++; $display("FAIL rnd%0d_timing op=%0d: lat=%0d illegal=%b want %0d/%b", i, op, lat, dec.illegal, ref_lat(op), !legal); end
      if (legal) begin
        n_vec++; if (wc != 1 || rf_waddr !== rd || rf_wdata !== res[7:0] || acc_hi !== res[15:8] || flags_q !== res[19:16]) begin
          n_err++; $display("FAIL rnd%0d_result op=%0d: we=%0d addr=%0d data=%h hi=%h flags=%b want 1/%0d/%h/%h/%b",
                            i, op, wc, rf_waddr, rf_wdata, acc_hi, flags_q, rd, res[7:0], res[15:8], res[19:16]); end
      end else begin
        n_vec++; if (wc != 0 || flags_q !== exp_flags || acc_hi !== exp_hi) begin
          n_err++; $display("FAIL rnd%0d_illegal op=%0d: we=%0d flags=%b hi=%h want 0/%b/%h", i, op, wc, flags_q, acc_hi, exp_flags, exp_hi); end
      end
      model_commit(op, rd, rs, imm);
      if ($urandom_range(0, 1) == 1) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    for (int r = 0; r < 8; r++) begin
      n_vec++; if (mem[r] !== exp_mem[r]) begin n_err++; $display("FAIL rnd_rf_r%0d: got %h want %h", r, mem[r], exp_mem[r]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    dec.start = 1'b0; dec.op = '0; dec.rd_sel = '0; dec.rs_sel = '0; dec.imm = '0;
    for (int r = 0; r < 8; r++) preload(3'(r), 8'($urandom_range(0, 255)));
    exp_flags = '0; exp_hi = '0;
    test_reset();
    test_sum();
    test_cm();
    test_sbi();
    test_illegal();
    test_reset_midop();
    test_mul();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
